// File: rtl/apb_chk_pkg.sv
// rtl/apb_chk_pkg.sv - shared types and constants for the APB protocol checker
package apb_chk_pkg;

  localparam int ERR_NUM = 8;

  typedef enum logic [2:0] {
    ERR_MULTI_SEL  = 3'd0,
    ERR_PEN_NO_SEL = 3'd1,
    ERR_SETUP_EN   = 3'd2,
    ERR_NO_ENABLE  = 3'd3,
    ERR_UNSTABLE   = 3'd4,
    ERR_DROP       = 3'd5,
    ERR_TIMEOUT    = 3'd6,
    ERR_STRB_READ  = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_e;

endpackage

// File: rtl/apb_chk_err_log.sv
// rtl/apb_chk_err_log.sv - priority-encodes per-cycle violations into pulse, sticky flags and saturating count
module apb_chk_err_log
  import apb_chk_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ERR_NUM-1:0]   viol,
  input  logic                 clr,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [ERR_NUM-1:0]   err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [2:0] code_nxt;
  logic       any_viol;

  assign any_viol = |viol;

  // Lowest-index violation wins: scan downward so the smallest set index is assigned last
  always_comb begin
    code_nxt = 3'd0;
    for (int i = ERR_NUM - 1; i >= 0; i--) begin
      if (viol[i]) code_nxt = 3'(i);
    end
  end

  // Register the report; a violation arriving with clr survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid  <= 1'b0;
      err_code   <= 3'd0;
      err_sticky <= '0;
      err_count  <= '0;
    end else begin
      err_valid <= any_viol;
      err_code  <= code_nxt;
      if (clr) begin
        err_sticky <= viol;
        err_count  <= any_viol ? ERR_CNT_W'(1) : '0;
      end else begin
        err_sticky <= err_sticky | viol;
        if (any_viol && (err_count != '1)) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// rtl/apb_protocol_checker.sv - passive APB3/APB4 transfer tracker and violation flagger (optional stats: APB_CHK_STATS_EN)
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int APB_AW    = 32,
  parameter int APB_DW    = 32,
  parameter int NUM_SLV   = 4,
  parameter int TIMEOUT   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [APB_AW-1:0]     paddr,
  input  logic [NUM_SLV-1:0]    psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_DW-1:0]     pwdata,
  input  logic [APB_DW/8-1:0]   pstrb,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic                  clr,
`ifdef APB_CHK_STATS_EN
  output logic [31:0]           xfer_count,
  output logic [15:0]           slverr_count,
  output logic [7:0]            max_wait,
`endif
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [ERR_NUM-1:0]    err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_e              state, state_nxt;
  logic [WCW-1:0]      wait_cnt, wait_cnt_nxt;
  logic [APB_AW-1:0]   cap_addr;
  logic [NUM_SLV-1:0]  cap_sel;
  logic                cap_write;
  logic [APB_DW-1:0]   cap_wdata;
  logic [APB_DW/8-1:0] cap_strb;
  logic [ERR_NUM-1:0]  viol;
  logic                any_sel, multi_sel, unstable, setup, done;

  assign any_sel   = |psel;
  assign multi_sel = |(psel & (psel - 1'b1));
  assign unstable  = (paddr != cap_addr) || (psel != cap_sel) || (pwrite != cap_write) ||
                     (pstrb != cap_strb) || (cap_write && (pwdata != cap_wdata));

  // Next-state, wait counting and per-cycle violation vector
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    viol         = '0;
    setup        = 1'b0;
    done         = 1'b0;
    viol[ERR_MULTI_SEL]  = multi_sel;
    viol[ERR_PEN_NO_SEL] = penable && !any_sel;
    case (state)
      IDLE: begin
        if (any_sel) begin
          setup               = 1'b1;
          viol[ERR_SETUP_EN]  = penable;
          viol[ERR_STRB_READ] = !pwrite && (pstrb != '0);
          wait_cnt_nxt        = '0;
          state_nxt           = ACCESS;
        end
      end
      ACCESS: begin
        if (!any_sel) begin
          viol[ERR_DROP] = 1'b1;
          state_nxt      = IDLE;
        end else if (!penable) begin
          viol[ERR_NO_ENABLE] = 1'b1;
          state_nxt           = RECOVER;
        end else begin
          viol[ERR_UNSTABLE] = unstable;
          if (pready) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
            if (wait_cnt == WCW'(TIMEOUT - 1)) begin
              viol[ERR_TIMEOUT] = 1'b1;
              state_nxt         = RECOVER;
            end
          end
        end
      end
      RECOVER: begin
        if (!any_sel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Snapshot of the setup-cycle bus, the reference for stability checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr  <= '0;
      cap_sel   <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else if (setup) begin
      cap_addr  <= paddr;
      cap_sel   <= psel;
      cap_write <= pwrite;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
    end
  end

  apb_chk_err_log #(.ERR_CNT_W(ERR_CNT_W)) u_err_log (
    .clk        (clk),
    .rst        (rst),
    .viol       (viol),
    .clr        (clr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

`ifdef APB_CHK_STATS_EN
  logic [7:0] wait8;
  logic       in_access;

  assign in_access = (state == ACCESS) && any_sel && penable;

  // Wait count clipped to the 8-bit statistic
  always_comb begin
    wait8 = 8'(wait_cnt_nxt);
    if (32'(wait_cnt_nxt) > 32'd255) wait8 = 8'hFF;
  end

  // Transfer statistics, saturating, cleared by clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count   <= '0;
      slverr_count <= '0;
      max_wait     <= '0;
    end else if (clr) begin
      xfer_count   <= '0;
      slverr_count <= '0;
      max_wait     <= '0;
    end else begin
      if (done && (xfer_count != '1)) xfer_count <= xfer_count + 1'b1;
      if (done && pslverr && (slverr_count != '1)) slverr_count <= slverr_count + 1'b1;
      if (in_access && (wait8 > max_wait)) max_wait <= wait8;
    end
  end
`else
  logic unused_slverr;
  assign unused_slverr = pslverr ^ done;
`endif

endmodule

// File: tb/tb_apb_protocol_checker.sv
// tb/tb_apb_protocol_checker.sv - scoreboard bench for apb_protocol_checker
module tb_apb_protocol_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic        clr;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [7:0]  err_sticky;
  logic [7:0]  err_count;

  typedef struct packed {
    logic       v;
    logic [2:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  apb_protocol_checker #(
    .APB_AW(32), .APB_DW(32), .NUM_SLV(4), .TIMEOUT(16), .ERR_CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .pslverr    (pslverr),
    .clr        (clr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  // Drive one bus cycle, queue its expected report, then check it one edge later
  task automatic step(input string tag, input logic [3:0] s, input logic en, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic rdy, input logic ev, input logic [2:0] ec);
    exp_t e;
    psel = s; penable = en; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pready = rdy;
    sb_q.push_back('{v: ev, c: ec});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if (err_valid !== e.v) begin
      n_bad++;
      $display("FAIL %s err_valid got %0b want %0b", tag, err_valid, e.v);
    end
    if (e.v) begin
      n_cmp++;
      if (err_code !== e.c) begin
        n_bad++;
        $display("FAIL %s err_code got %0d want %0d", tag, err_code, e.c);
      end
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic do_clear(input string tag);
    clr = 1'b1;
    idle(tag);
    clr = 1'b0;
    n_cmp++;
    if (err_sticky !== 8'h00 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL %s sticky/count got %h/%0d want 00/0", tag, err_sticky, err_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; pslverr = 1'b0;
    psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; pready = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (err_valid !== 1'b0 || err_code !== 3'd0 || err_sticky !== 8'h00 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset outputs got %b/%0d/%h/%0d want 0/0/00/0", err_valid, err_code, err_sticky, err_count);
    end
    rst = 1'b0;
    idle("reset_idle");
  endtask

  task automatic test_legal_write();
    step("lw_setup", 4'b0010, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    step("lw_wait1", 4'b0010, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    step("lw_wait2", 4'b0010, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    step("lw_done",  4'b0010, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    idle("lw_idle");
    n_cmp++;
    if (err_sticky !== 8'h00 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL legal_write sticky/count got %h/%0d want 00/0", err_sticky, err_count);
    end
  endtask

  task automatic test_multi_sel();
    step("ms_setup", 4'b0011, 0, 1, 32'h80, 32'h1234, 4'hF, 0, 1, 3'd0);
    n_cmp++;
    if (err_sticky !== 8'b0000_0001 || err_count !== 8'd1) begin
      n_bad++;
      $display("FAIL multi_sel sticky/count got %h/%0d want 01/1", err_sticky, err_count);
    end
    step("ms_access", 4'b0011, 1, 1, 32'h80, 32'h1234, 4'hF, 1, 1, 3'd0);
    idle("ms_idle");
    n_cmp++;
    if (err_count !== 8'd2) begin
      n_bad++;
      $display("FAIL multi_sel count2 got %0d want 2", err_count);
    end
    do_clear("ms_clr");
  endtask

  task automatic test_unstable();
    step("us_setup", 4'b0010, 0, 1, 32'h40, 32'hA5A5, 4'h3, 0, 0, 0);
    step("us_acc1",  4'b0010, 1, 1, 32'h40, 32'hA5A5, 4'h3, 0, 0, 0);
    step("us_acc2",  4'b0010, 1, 1, 32'h44, 32'hA5A5, 4'h3, 0, 1, 3'd4);
    step("us_done",  4'b0010, 1, 1, 32'h40, 32'hA5A5, 4'h3, 1, 0, 0);
    idle("us_idle");
    n_cmp++;
    if (err_sticky !== 8'b0001_0000 || err_count !== 8'd1) begin
      n_bad++;
      $display("FAIL unstable sticky/count got %h/%0d want 10/1", err_sticky, err_count);
    end
    do_clear("us_clr");
  endtask

  task automatic test_timeout();
    step("to_setup", 4'b0100, 0, 0, 32'h100, 32'h0, 4'h0, 0, 0, 0);
    for (int i = 1; i <= 16; i++)
      step($sformatf("to_wait%0d", i), 4'b0100, 1, 0, 32'h100, 32'h0, 4'h0, 0, (i == 16), 3'd6);
    step("to_rec1", 4'b0100, 1, 0, 32'h100, 32'h0, 4'h0, 0, 0, 0);
    step("to_rec2", 4'b0100, 0, 0, 32'h100, 32'h0, 4'h0, 0, 0, 0);
    idle("to_release");
    step("to_nsetup", 4'b0001, 0, 0, 32'h200, 32'h0, 4'h0, 0, 0, 0);
    step("to_ndone",  4'b0001, 1, 0, 32'h200, 32'h0, 4'h0, 1, 0, 0);
    idle("to_nidle");
    n_cmp++;
    if (err_sticky !== 8'b0100_0000 || err_count !== 8'd1) begin
      n_bad++;
      $display("FAIL timeout sticky/count got %h/%0d want 40/1", err_sticky, err_count);
    end
    do_clear("to_clr");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++)
      step("sat_pen", 4'b0000, 1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 3'd1);
    idle("sat_idle");
    n_cmp++;
    if (err_count !== 8'd255 || err_sticky !== 8'b0000_0010) begin
      n_bad++;
      $display("FAIL saturate count/sticky got %0d/%h want 255/02", err_count, err_sticky);
    end
    do_clear("sat_clr");
    clr = 1'b1;
    step("sat_clr_viol", 4'b0000, 1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 3'd1);
    clr = 1'b0;
    n_cmp++;
    if (err_count !== 8'd1 || err_sticky !== 8'b0000_0010) begin
      n_bad++;
      $display("FAIL clr_vs_viol count/sticky got %0d/%h want 1/02", err_count, err_sticky);
    end
    do_clear("sat_clr2");
  endtask

  task automatic test_back_to_back();
    step("bb_a_setup", 4'b1000, 0, 1, 32'h10, 32'h11, 4'hF, 0, 0, 0);
    step("bb_a_done",  4'b1000, 1, 1, 32'h10, 32'h11, 4'hF, 1, 0, 0);
    step("bb_b_setup", 4'b1000, 0, 0, 32'h14, 32'h0,  4'h0, 0, 0, 0);
    step("bb_b_done",  4'b1000, 1, 0, 32'h14, 32'h0,  4'h0, 1, 0, 0);
    idle("bb_idle");
    n_cmp++;
    if (err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL back_to_back count got %0d want 0", err_count);
    end
  endtask

  task automatic test_setup_en_reset();
    step("se_setup", 4'b0001, 1, 0, 32'h300, 32'h0, 4'hF, 0, 1, 3'd2);
    n_cmp++;
    if (err_sticky !== 8'b1000_0100) begin
      n_bad++;
      $display("FAIL setup_en sticky got %b want 10000100", err_sticky);
    end
    step("se_wait", 4'b0001, 1, 0, 32'h300, 32'h0, 4'hF, 0, 0, 0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (err_valid !== 1'b0 || err_code !== 3'd0 || err_sticky !== 8'h00 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL midreset outputs got %b/%0d/%h/%0d want 0/0/00/0", err_valid, err_code, err_sticky, err_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("se_after_rst");
  endtask

  initial begin
    test_reset();
    test_legal_write();
    test_multi_sel();
    test_unstable();
    test_timeout();
    test_saturate();
    test_back_to_back();
    test_setup_en_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_protocol_checker.md
Name: apb_protocol_checker

Overview:
- Synthesizable APB3/APB4 protocol checker; passively snoops one APB bus shared by NUM_SLV slaves.
- Tracks each transfer with a small FSM and flags protocol violations as coded error events, sticky flags and a saturating count.
- Sits beside the bus in RTL or emulation builds, where simulation-only assertions are unavailable.

Parameters:
APB_AW, 32, address width
APB_DW, 32, data width (multiple of 8)
NUM_SLV, 4, number of psel lines (1..16)
TIMEOUT, 16, max wait states before timeout error (>=1)
ERR_CNT_W, 8, error counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
paddr  in  APB_AW  snooped address
psel  in  NUM_SLV  snooped one-hot slave selects
penable  in  1  snooped enable
pwrite  in  1  snooped direction
pwdata  in  APB_DW  snooped write data
pstrb  in  APB_DW/8  snooped write strobes
pready  in  1  snooped ready
pslverr  in  1  snooped slave error
clr  in  1  clears err_sticky and err_count
err_valid  out  1  one-cycle pulse, violation detected
err_code  out  3  lowest-index violation of that cycle
err_sticky  out  8  per-code sticky flags
err_count  out  ERR_CNT_W  saturating count of err_valid pulses

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (rst). All outputs and state clear to 0 on reset, FSM to IDLE.
- Error codes:
  - 0 MULTI_SEL: >1 psel bit high, any state.
  - 1 PEN_NO_SEL: penable=1 with psel=0, any state.
  - 2 SETUP_EN: penable=1 in the setup cycle.
  - 3 NO_ENABLE: psel held, penable=0, in ACCESS.
  - 4 UNSTABLE: paddr/psel/pwrite/pstrb (and pwdata if write) differ from the setup capture, in ACCESS.
  - 5 DROP: psel=0 in ACCESS before pready.
  - 6 TIMEOUT.
  - 7 STRB_READ: pwrite=0 with pstrb!=0 during setup.
- FSM IDLE:
  - Cycle with |psel is the setup cycle. Check codes 2 and 7, capture paddr/psel/pwrite/pwdata/pstrb, wait_cnt=0, go ACCESS.
- FSM ACCESS:
  - psel==0 -> code 5, go IDLE.
  - penable==0 -> code 3, go RECOVER.
  - Otherwise check code 4.
  - pready=1 -> transfer done, go IDLE. A back-to-back setup on the next cycle is handled by IDLE.
  - pready=0 -> wait_cnt++; when wait_cnt reaches TIMEOUT with pready still 0 -> code 6, go RECOVER.
- FSM RECOVER: stay until psel==0, then IDLE. No codes 3-6 are raised here.
- Reporting latency: violations are detected combinationally and registered, so err_valid/err_code appear 1 cycle after the offending clk edge.
- Multiple violations in one cycle: err_code = lowest index; all matching err_sticky bits set.
- err_count increments once per err_valid and saturates at all-ones.
- clr in the same cycle as a new violation: the new violation's sticky bits and count = 1 win over the clear.
- Reset mid-transfer aborts tracking and raises no error.

Optional Feature:
APB_CHK_STATS_EN
- Defined: adds outputs xfer_count[31:0] (completed transfers), slverr_count[15:0] (completions with pslverr=1) and max_wait[7:0] (largest wait_cnt seen). All saturating and cleared by clr.
- Undefined: these ports and registers are absent.

Decomposition:
- Package apb_chk_pkg:
  - err_code_e enum (the 8 codes)
  - state_e enum (IDLE, ACCESS, RECOVER)
  - ERR_NUM=8 constant
- Sub-module apb_chk_err_log: takes the 8-bit per-cycle violation vector and clr; produces err_valid, err_code, err_sticky, err_count (priority encode + sticky + saturating count).
- FSM and capture logic stay in the top module.

Test Plan:
- Legal write, psel=4'b0010, addr 0x40, 2 wait states, pready on 3rd access cycle -> no err_valid, err_sticky=0.
- psel=4'b0011 in setup -> err_valid one cycle later, err_code=0, err_sticky[0]=1, err_count=1.
- paddr changes 0x40->0x44 in 2nd access cycle while pready=0 -> err_code=4; transfer completes normally after.
- TIMEOUT=16, pready held 0 -> err_code=6 after the 16th wait cycle; FSM in RECOVER until psel=0; next legal transfer gives no error.
- 300 violations with ERR_CNT_W=8 -> err_count stays 255; clr asserted alone -> err_count=0, err_sticky=0.
- Read setup with pstrb=4'hF and penable=1 -> err_code=2, err_sticky=8'b1000_0100; rst mid-ACCESS -> all outputs 0 immediately.
